// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a little-endian byte program into instruction memory, holding the CPU in reset until loaded
// Optional trailer checksum verification: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        start_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd3;
`endif
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  logic [2:0]  state;
  logic [15:0] len_r;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [31:0] rx_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  // Complete word as it will look once the current byte is taken as byte 3.
  assign rx_word = {rx_data_i, asm_word[23:0]};

  always_ff @(posedge clk_i or posedge nrst_i) begin
    if (nrst_i) begin
      state    <= IDLE;
      len_r    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      addr_r   <= '0;
      data_r   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            if ({1'b0, len_i} > DEPTH_L) begin
              state <= ERR;
            end else if (len_i == 16'd0) begin
              state <= DONE;
            end else begin
              state    <= LOAD;
              len_r    <= len_i;
              word_cnt <= '0;
              byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              checksum <= '0;
`endif
            end
          end
        end
        LOAD: begin
          if (rx_valid_i) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr_r <= {14'd0, word_cnt, 2'b00};
              data_r <= rx_word;
              state  <= WRITE;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum <= checksum ^ data_r;
          state    <= (word_cnt + 16'd1 < len_r) ? LOAD : CHECK;
`else
          state    <= (word_cnt + 16'd1 < len_r) ? LOAD : DONE;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid_i) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= (rx_word == checksum) ? DONE : ERR;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready_o = (state == LOAD) || (state == CHECK);
  assign busy_o     = (state == LOAD) || (state == WRITE) || (state == CHECK);
`else
  assign rx_ready_o = (state == LOAD);
  assign busy_o     = (state == LOAD) || (state == WRITE);
`endif
  assign imem_we_o   = (state == WRITE);
  assign imem_addr_o = addr_r;
  assign imem_data_o = data_r;
  assign cpu_rst_o   = (state != DONE);
  assign done_o      = (state == DONE);
  assign err_o       = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
// Adapts to IMEM_LOADER_CHECKSUM_EN when the macro is defined for the build.
module tb_imem_loader;

  localparam int DEPTH = 16;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk_i       (clk),
    .nrst_i      (rst),
    .start_i     (start),
    .len_i       (len_i),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_data_o (imem_data),
    .cpu_rst_o   (cpu_rst),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] prog[DEPTH+1];
  int          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none", imem_addr, imem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e.addr);
        check("wr_data", imem_data, mon_e.data);
        check("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    acc = -1;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      t++;
      @(posedge clk);
      #1;
    end
    if (ok) acc = cyc;
    else begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept_timeout: got no rx_ready, expected acceptance");
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    len_i = 16'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (len > DEPTH) begin
      check("start_err", err, 1'b1);
      check("start_err_cpu_rst", cpu_rst, 1'b1);
      check("start_err_busy", busy, 1'b0);
    end else if (len == 0) begin
      check("start_zero_done", done, 1'b1);
      check("start_zero_cpu_rst", cpu_rst, 1'b0);
    end else begin
      check("start_busy", busy, 1'b1);
      check("start_cpu_rst", cpu_rst, 1'b1);
      check("start_rx_ready", rx_ready, 1'b1);
      check("start_done", done, 1'b0);
    end
  endtask

  task automatic wait_end(input bit exp_err);
    int t;
    t = 0;
    @(negedge clk);
    while (!(done || err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("end_cycle", cyc, last_acc + (CSUM ? 0 : 1));
    check("end_done", done, !exp_err);
    check("end_err", err, exp_err);
    check("end_cpu_rst", cpu_rst, exp_err);
    check("end_busy", busy, 1'b0);
    check("end_rx_ready", rx_ready, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int len, input int gmin, input int gmax, input bit corrupt);
    int          acc;
    logic [31:0] csum;
    logic [31:0] w;
    csum = '0;
    do_start(len);
    for (int i = 0; i < len; i++) begin
      w = prog[i];
      csum ^= w;
      for (int k = 0; k < 4; k++) begin
        if (i != 0 || k != 0) idle_cycles($urandom_range(gmax, gmin));
        send_byte(w[8*k +: 8], acc);
        if (k == 3) exp_q.push_back('{addr: 32'(i * 4), data: w, cyc: acc});
        last_acc = acc;
      end
    end
    if (CSUM) begin
      if (corrupt) csum ^= 32'h1;
      for (int k = 0; k < 4; k++) begin
        idle_cycles($urandom_range(gmax, gmin));
        send_byte(csum[8*k +: 8], acc);
        last_acc = acc;
      end
    end
    wait_end(CSUM && corrupt);
    check("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1;
    start = 1'b0;
    len_i = '0;
    rx_data = '0;
    rx_valid = 1'b0;
    last_acc = 0;
    #12;
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_data", imem_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    // Two-word program, back-to-back and then with 3-cycle gaps.
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0000_00B3;
    run_load(2, 0, 0, 1'b0);
    run_load(2, 3, 3, 1'b0);
    if (CSUM) run_load(2, 0, 0, 1'b1);

    // Degenerate lengths.
    do_start(0);
    idle_cycles(3);
    check("zero_len_done_hold", done, 1'b1);
    do_start(DEPTH + 1);
    idle_cycles(3);
    check("overflow_err_hold", err, 1'b1);
    check("overflow_cpu_rst_hold", cpu_rst, 1'b1);
    check("pending_writes_len", exp_q.size(), 0);

    // Reset after 5 of 8 bytes: only word 0 lands.
    do_start(2);
    for (int k = 0; k < 5; k++) begin
      send_byte(prog[k / 4][8*(k % 4) +: 8], acc);
      if (k == 3) exp_q.push_back('{addr: 32'h0, data: prog[0], cyc: acc});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_ready", rx_ready, 1'b0);
    check("midrst_we", imem_we, 1'b0);
    check("midrst_cpu_rst", cpu_rst, 1'b1);
    check("midrst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(3);
    check("midrst_pending", exp_q.size(), 0);
    run_load(2, 0, 1, 1'b0);

    // Randomized programs, including a full-depth one.
    for (int n = 0; n < 10; n++) begin
      int len;
      len = (n == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
      for (int i = 0; i < len; i++) prog[i] = $urandom;
      run_load(len, 0, 2, CSUM ? 1'($urandom_range(1, 0)) : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port nrst_i, input, 1, the reset: asynchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1, a load request sampled in IDLE, DONE or ERR.
REQ-005 The block SHALL have port len_i, input, 16, the program length in words, sampled on the cycle start_i is accepted.
REQ-006 The block SHALL have port rx_data_i, input, 8, the program byte stream.
REQ-007 The block SHALL have port rx_valid_i, input, 1, meaning rx_data_i is valid.
REQ-008 The block SHALL have port rx_ready_o, output, 1; a byte transfers on a cycle where rx_valid_i and rx_ready_o are both 1.
REQ-009 The block SHALL have port imem_we_o, output, 1, the instruction-memory write strobe.
REQ-010 The block SHALL have port imem_addr_o, output, 32, the byte address (word index * 4).
REQ-011 The block SHALL have port imem_data_o, output, 32, the write data.
REQ-012 The block SHALL have port cpu_rst_o, output, 1, an active-high hold-in-reset for the CPU and program counter.
REQ-013 The block SHALL have ports busy_o, done_o and err_o, each output, 1, as status flags.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, WRITE, CHECK, DONE and ERR.
REQ-015 From IDLE, DONE or ERR, start_i=1 SHALL: go to ERR if len_i > DEPTH_WORDS; go to DONE if len_i == 0; otherwise go to LOAD, clearing word_cnt, byte_cnt and the checksum.
REQ-016 In LOAD, rx_ready_o SHALL be 1; each accepted byte k (k = 0..3) SHALL be placed in bits [8k+7:8k] of the word being assembled (little-endian).
REQ-017 Acceptance of byte 3 SHALL move the block to WRITE.
REQ-018 WRITE SHALL last exactly one cycle with imem_we_o=1, imem_addr_o = word_cnt*4 and imem_data_o = the assembled word.
REQ-019 rx_ready_o SHALL be 0 in WRITE.
REQ-020 After WRITE, word_cnt SHALL increment; the block SHALL go to LOAD if word_cnt < len, otherwise to CHECK (macro defined) or DONE (macro undefined).
REQ-021 Latency SHALL be one cycle from acceptance of the last byte of a word to its write strobe.
REQ-022 Idle cycles (rx_valid_i=0) SHALL stall assembly with no state loss.
REQ-023 In DONE, cpu_rst_o=0 and done_o=1; in all other states, cpu_rst_o=1.
REQ-024 busy_o SHALL be 1 in LOAD, WRITE and CHECK.
REQ-025 In ERR, err_o=1 and cpu_rst_o=1 until the next start_i.
REQ-026 start_i SHALL be ignored in LOAD, WRITE and CHECK.
REQ-027 A restart from DONE SHALL reassert cpu_rst_o on the next cycle.
REQ-028 imem_we_o SHALL be 0 in every state except WRITE.
REQ-029 imem_addr_o and imem_data_o SHALL hold their last values outside WRITE.
REQ-030 The address SHALL never exceed (DEPTH_WORDS-1)*4; no wrap-around write shall occur.

Reset
REQ-031 nrst_i=1 SHALL immediately force state=IDLE, word_cnt=0, byte_cnt=0 and checksum=0.
REQ-032 During reset, outputs SHALL be rx_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_data_o=0, busy_o=0, done_o=0, err_o=0 and cpu_rst_o=1.
REQ-033 Reset mid-load SHALL abort the load with no further writes; words already written remain in memory.

Configuration
REQ-034 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL XOR every written word into a 32-bit checksum.
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept 4 further bytes (little-endian, rx_ready_o=1) with no memory write.
REQ-036 With IMEM_LOADER_CHECKSUM_EN defined, a checksum match SHALL go to DONE and a mismatch SHALL go to ERR.
REQ-037 Without IMEM_LOADER_CHECKSUM_EN, the CHECK state and checksum register SHALL be absent, and the stream SHALL be exactly len*4 bytes.

Verification
REQ-038 Bench SHALL cover: start_i, len_i=2, bytes 13 00 00 00 B3 00 00 00 back-to-back -> writes (0x0, 0x00000013) then (0x4, 0x000000B3), each one cycle after the 4th byte; then DONE with cpu_rst_o=0 (macro off).
REQ-039 Bench SHALL cover: the same stream with rx_valid_i low for 3 cycles between bytes -> identical writes, no extra strobes.
REQ-040 Bench SHALL cover: len_i=0 -> DONE the next cycle with no writes; len_i=DEPTH_WORDS+1 -> ERR, err_o=1, cpu_rst_o=1.
REQ-041 Bench SHALL cover: macro on, words 0x00000013 and 0x000000B3, trailer 0x000000A0 -> DONE; trailer 0x000000A1 -> ERR.
REQ-042 Bench SHALL cover: nrst_i pulsed after 5 of 8 bytes -> IDLE immediately, only word 0 written, cpu_rst_o=1; a new start reloads from address 0.
